// File: rtl/tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Round-robin arbiter that hands one shared output net to one of N tri-state
// driver cells at a time. Between two owners every enable is held low for
// DEAD_CYCLES cycles, so one driver's turn-off never overlaps another
// driver's turn-on. An owner that keeps the net while someone else is
// waiting is preempted after MAX_HOLD cycles. An owner with no competition
// may keep the net for as long as it likes.
//
// Parameters:
//   N           number of requesters / drivers (>= 2)
//   DEAD_CYCLES all-enables-off cycles between two grants (>= 1)
//   MAX_HOLD    grant cycles allowed while another requester waits (>= 1)
//
// Ports:
//   clk     in   1          clock, rising edge
//   rst_n   in   1          asynchronous active-low reset
//   req     in   N          level requests, held for the whole use
//   en      out  N          registered driver enables, one-hot or zero
//   gnt_id  out  clog2(N)   index of the current owner, 0 when not busy
//   busy    out  1          high while any enable is set
//   dead    out  1          high during dead-time cycles
// ----------------------------------------------------------------------------
module tristate_bus_arbiter #(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 dead
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] ID_LAST   = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DEAD
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  ptr, ptr_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [DW-1:0]  dead_cnt, dcnt_n;
    logic [N-1:0]   en_n;
    logic [IW-1:0]  gnt_n;
    logic           busy_n;
    logic           dead_n;

    logic           any_req;
    logic           found;
    logic [IW-1:0]  win_id;
    logic [N-1:0]   win_onehot;
    logic [IW-1:0]  win_next_ptr;
    logic           others_req;
    logic           grant_now;
    int             scan_idx;

    // Round-robin pick: walk the request vector starting at ptr and wrap
    // around; the first requester seen wins. Also derives the pointer value
    // that puts the winner last in line for the next arbitration.
    always_comb begin
        any_req  = |req;
        found    = 1'b0;
        win_id   = '0;
        scan_idx = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(ptr) + k) % N;
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                win_id = IW'(scan_idx);
            end
        end
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
        win_next_ptr       = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
    end

    // While granted, en holds exactly the owner's bit, so masking it out
    // leaves only the requesters that are waiting on the owner.
    assign others_req = |(req & ~en);

    // Next-state and next-output logic. Every register holds its value by
    // default; the case below only spells out what changes. A grant is
    // raised as a flag so IDLE and the end of DEAD share one grant path.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        dcnt_n    = dead_cnt;
        en_n      = en;
        gnt_n     = gnt_id;
        busy_n    = busy;
        dead_n    = dead;
        grant_now = 1'b0;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_now = 1'b1;
                end
            end

            ST_GRANT: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + 1'b1;
                end
                // A release wins over preemption; both lead to the same
                // dead-time entry so no extra bookkeeping is needed.
                if (!req[gnt_id] || ((hold_cnt == HOLD_LAST) && others_req)) begin
                    state_n = ST_DEAD;
                    en_n    = '0;
                    busy_n  = 1'b0;
                    gnt_n   = '0;
                    dead_n  = 1'b1;
                    dcnt_n  = '0;
                end
            end

            ST_DEAD: begin
                dcnt_n = dead_cnt + 1'b1;
                // The dead time always runs to completion, even if every
                // request disappears partway through it.
                if (dead_cnt == DEAD_LAST) begin
                    dead_n = 1'b0;
                    if (any_req) begin
                        grant_now = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (grant_now) begin
            state_n = ST_GRANT;
            en_n    = win_onehot;
            gnt_n   = win_id;
            busy_n  = 1'b1;
            ptr_n   = win_next_ptr;
            hold_n  = '0;
        end
    end

    // State and output registers. Reset is asynchronous so the enables drop
    // the moment rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            dead_cnt <= '0;
            en       <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            dead     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            dead_cnt <= dcnt_n;
            en       <= en_n;
            gnt_id   <= gnt_n;
            busy     <= busy_n;
            dead     <= dead_n;
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//
// Directed bench for tristate_bus_arbiter with N=4, DEAD_CYCLES=2,
// MAX_HOLD=4. Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point, well away from the next active edge. All
// expected values are worked out by hand from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] gnt_id;
    logic       busy;
    logic       dead;

    int totalCount = 0;
    int badCount   = 0;

    tristate_bus_arbiter #(
        .N          (4),
        .DEAD_CYCLES(2),
        .MAX_HOLD   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (en),
        .gnt_id(gnt_id),
        .busy  (busy),
        .dead  (dead)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        req = value;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for two edges with no requests, release it mid-cycle.
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expEn,
                            input logic [1:0] expId, input logic expBusy,
                            input logic expDead);
        checkOutput({tag, ".en"},     32'(en),     32'(expEn));
        checkOutput({tag, ".gnt_id"}, 32'(gnt_id), 32'(expId));
        checkOutput({tag, ".busy"},   32'(busy),   32'(expBusy));
        checkOutput({tag, ".dead"},   32'(dead),   32'(expDead));
    endtask

    initial begin
        logic [3:0] expEn;
        int         phase;
        int         owner;

        rst_n = 1'b0;
        req   = 4'b0000;

        // ---------------- reset behaviour ----------------
        tick(1);
        checkAll("rst_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'b0010);
        tick(1);
        checkAll("rst_first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(2);
        checkOutput("rst_hold_en", 32'(en), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_en", 32'(en), 32'h0);
        checkOutput("rst_async_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
        tick(1);
        checkAll("rst_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // ---------------- single user ----------------
        doReset();
        applyStimulus(4'b0100);
        tick(1);
        checkAll("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick(4);
        checkAll("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        tick(1);
        checkAll("single_dead1", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("single_dead2", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        checkAll("single_idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ---------------- full contention ----------------
        // Period of 6 edges: 4 granted cycles then 2 dead cycles, owners
        // rotating 0,1,2,3,0.
        doReset();
        applyStimulus(4'b1111);
        for (int k = 0; k < 26; k++) begin
            tick(1);
            phase = k % 6;
            owner = (k / 6) % 4;
            expEn = (phase < 4) ? (4'b0001 << owner) : 4'b0000;
            checkOutput($sformatf("full_en_k%0d", k), 32'(en), 32'(expEn));
            checkOutput($sformatf("full_onehot_k%0d", k), 32'($countones(en) <= 1), 32'h1);
            if (phase == 0) begin
                checkOutput($sformatf("full_id_k%0d", k), 32'(gnt_id), 32'(owner));
            end
            if (phase == 4) begin
                checkOutput($sformatf("full_dead_k%0d", k), 32'(dead), 32'h1);
            end
        end

        // ---------------- late contention ----------------
        doReset();
        applyStimulus(4'b0010);
        tick(1);
        checkOutput("late_grant", 32'(en), 32'h2);
        tick(9);
        checkOutput("late_long_hold", 32'(en), 32'h2);
        applyStimulus(4'b1010);
        tick(1);
        checkAll("late_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("late_dead2", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("late_new_owner", 4'b1000, 2'd3, 1'b1, 1'b0);

        // ---------------- handover ----------------
        doReset();
        applyStimulus(4'b0001);
        tick(2);
        checkOutput("hand_owner0", 32'(en), 32'h1);
        applyStimulus(4'b0100);
        tick(1);
        checkAll("hand_dead1", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("hand_dead2", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("hand_owner2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // ---------------- withdrawal during dead time ----------------
        doReset();
        applyStimulus(4'b0001);
        tick(1);
        applyStimulus(4'b0100);
        tick(1);
        checkAll("wd_dead1", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0000);
        tick(1);
        checkAll("wd_dead2", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        checkAll("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        checkOutput("wd_idle2_en", 32'(en), 32'h0);

        // ---------------- round-robin fairness ----------------
        doReset();
        applyStimulus(4'b0010);
        tick(1);
        checkOutput("rr_owner1", 32'(en), 32'h2);
        applyStimulus(4'b1011);
        tick(1);
        checkOutput("rr_owner1_hold", 32'(en), 32'h2);
        applyStimulus(4'b1001);
        tick(1);
        checkOutput("rr_release", 32'(en), 32'h0);
        tick(1);
        applyStimulus(4'b1011);
        tick(1);
        checkAll("rr_owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(3);
        checkOutput("rr_owner3_last", 32'(en), 32'h8);
        tick(1);
        checkOutput("rr_preempt3", 32'(en), 32'h0);
        tick(2);
        checkAll("rr_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(6);
        checkAll("rr_owner1_again", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
